// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2
    } state_e;

    function automatic logic opIsMul(input op_e o);
        return (o == OP_MULT) || (o == OP_MULTU);
    endfunction

    function automatic logic opIsSigned(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: magnitude on the way in, sign restore on the way out.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? WIDTH'(WIDTH'(0) - value) : value;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and hazard-unit stall.
// Optional early termination enabled by defining MULDIV_EARLY_OUT_EN.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] hiloWriteData,
    input  logic             hiloRead,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned W2    = 2 * WIDTH;

    state_e           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [W2-1:0]    acc, accNext;
    logic [WIDTH-1:0] opnd, opndNext;
    op_e              opReg, opNext;
    logic             signRes, signResNext;
    logic             signA, signANext;
    logic [WIDTH-1:0] hiNext, loNext;
    logic             divZeroNext, doneNext, busyNext;

    // Operand decode and magnitudes at launch
    op_e              opIn;
    logic             inSigned, inMul, aNegIn, bNegIn;
    logic [WIDTH-1:0] aMag, bMag;

    assign opIn     = op_e'(op);
    assign inSigned = opIsSigned(opIn);
    assign inMul    = opIsMul(opIn);
    assign aNegIn   = inSigned & srcA[WIDTH-1];
    assign bNegIn   = inSigned & srcB[WIDTH-1];

    muldiv_sign_fix #(.WIDTH(WIDTH)) uAbsA (.value(srcA), .negate(aNegIn), .result(aMag));
    muldiv_sign_fix #(.WIDTH(WIDTH)) uAbsB (.value(srcB), .negate(bNegIn), .result(bMag));

    // One radix-2 step: acc = {upper half, multiplier or quotient bits}
    logic             curMul;
    logic [WIDTH:0]   mulSum;
    logic [W2-1:0]    mulAcc;
    logic [WIDTH:0]   divShift;
    logic             divGe;
    logic [WIDTH-1:0] divRem;
    logic [W2-1:0]    divAcc;

    assign curMul   = opIsMul(opReg);
    assign mulSum   = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
    assign mulAcc   = {mulSum, acc[WIDTH-1:1]};
    assign divShift = acc[W2-1:WIDTH-1];
    assign divGe    = divShift >= {1'b0, opnd};
    assign divRem   = WIDTH'(divShift[WIDTH-1:0] - opnd);
    assign divAcc   = {(divGe ? divRem : divShift[WIDTH-1:0]), acc[WIDTH-2:0], divGe};

    // Result sign correction
    logic [W2-1:0]    prodRaw, prodFix;
    logic [WIDTH-1:0] quoFix, remFix;

`ifdef MULDIV_EARLY_OUT_EN
    logic [CNT_W-1:0] shAmt;
    logic             earlyMul, earlyDiv;

    // Early exit leaves the product misaligned by the skipped iterations
    assign shAmt    = CNT_W'(WIDTH) - cnt;
    assign prodRaw  = acc >> shAmt;
    assign earlyMul = (WIDTH'(mulAcc[WIDTH-1:0] << (cnt + CNT_W'(1))) == WIDTH'(0));
    assign earlyDiv = (cnt == CNT_W'(0)) && (opnd > acc[WIDTH-1:0]);
`else
    assign prodRaw  = acc;
`endif

    muldiv_sign_fix #(.WIDTH(W2))    uFixProd (.value(prodRaw), .negate(signRes), .result(prodFix));
    muldiv_sign_fix #(.WIDTH(WIDTH)) uFixQuo  (.value(acc[WIDTH-1:0]), .negate(signRes), .result(quoFix));
    muldiv_sign_fix #(.WIDTH(WIDTH)) uFixRem  (.value(acc[W2-1:WIDTH]), .negate(signA), .result(remFix));

    // Next-state, datapath and commit logic
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        accNext     = acc;
        opndNext    = opnd;
        opNext      = opReg;
        signResNext = signRes;
        signANext   = signA;
        hiNext      = hi;
        loNext      = lo;
        divZeroNext = divZero;
        doneNext    = 1'b0;

        case (state)
            S_IDLE: begin
                if (hiWrite) hiNext = hiloWriteData;
                if (loWrite) loNext = hiloWriteData;
                if (start) begin
                    stateNext   = S_RUN;
                    cntNext     = CNT_W'(0);
                    opNext      = opIn;
                    signANext   = aNegIn;
                    signResNext = aNegIn ^ bNegIn;
                    opndNext    = inMul ? aMag : bMag;
                    accNext     = {WIDTH'(0), (inMul ? bMag : aMag)};
                end
            end
            S_RUN: begin
                cntNext = cnt + CNT_W'(1);
                accNext = curMul ? mulAcc : divAcc;
                if (cnt == CNT_W'(WIDTH - 1)) stateNext = S_FIXUP;
`ifdef MULDIV_EARLY_OUT_EN
                if (curMul && earlyMul) stateNext = S_FIXUP;
                if (!curMul && earlyDiv) begin
                    accNext   = {acc[WIDTH-1:0], WIDTH'(0)};
                    stateNext = S_FIXUP;
                end
`endif
            end
            S_FIXUP: begin
                stateNext = S_IDLE;
                doneNext  = 1'b1;
                if (curMul) begin
                    hiNext = prodFix[W2-1:WIDTH];
                    loNext = prodFix[WIDTH-1:0];
                end else begin
                    hiNext      = remFix;
                    loNext      = (opnd == WIDTH'(0)) ? {WIDTH{1'b1}} : quoFix;
                    divZeroNext = (opnd == WIDTH'(0));
                end
            end
            default: stateNext = S_IDLE;
        endcase

        // Flush aborts before anything in flight commits
        if (flush) begin
            stateNext = S_IDLE;
            doneNext  = 1'b0;
            if (state != S_IDLE) begin
                hiNext      = hi;
                loNext      = lo;
                divZeroNext = divZero;
            end
        end
    end

    assign busyNext = (stateNext != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= CNT_W'(0);
            acc     <= W2'(0);
            opnd    <= WIDTH'(0);
            opReg   <= OP_MULT;
            signRes <= 1'b0;
            signA   <= 1'b0;
            hi      <= WIDTH'(0);
            lo      <= WIDTH'(0);
            divZero <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            acc     <= accNext;
            opnd    <= opndNext;
            opReg   <= opNext;
            signRes <= signResNext;
            signA   <= signANext;
            hi      <= hiNext;
            lo      <= loNext;
            divZero <= divZeroNext;
            done    <= doneNext;
            busy    <= busyNext;
        end
    end

    assign stall = busy & (hiloRead | start | hiWrite | loWrite);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed table, random ops against an arithmetic model, corner sequences.
module tb_ex_muldiv_unit;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst, start, flush, hiWrite, loWrite, hiloRead;
    logic [1:0]    op;
    logic [W-1:0]  srcA, srcB, hiloWriteData;
    logic          busy, stall, done, divZero;
    logic [W-1:0]  hi, lo;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .flush(flush), .hiWrite(hiWrite), .loWrite(loWrite), .hiloWriteData(hiloWriteData),
        .hiloRead(hiloRead), .busy(busy), .stall(stall), .done(done), .divZero(divZero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, expHi, expLo;
        logic         expDz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op = o; srcA = a; srcB = b; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        while (!done && lat < 200) begin
            step();
            lat++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", lat);
        end
    endtask

    task automatic checkLatency(input string name, input int lat);
`ifndef MULDIV_EARLY_OUT_EN
        check(name, 64'(lat), 64'(LAT));
`else
        check(name, 64'(lat >= 2 && lat <= LAT), 64'(1));
`endif
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definition
    task automatic refModel(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] h, output logic [W-1:0] l);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            2'd1: begin p = 64'(a) * 64'(b); h = p[63:32]; l = p[31:0]; end
            2'd2: begin
                if (b == 0) begin h = a; l = '1; end
                else begin q = sa / sb; r = sa % sb; h = W'(r); l = W'(q); end
            end
            default: begin
                if (b == 0) begin h = a; l = '1; end
                else begin h = a % b; l = a / b; end
            end
        endcase
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    vec_t tbl[10];

    initial begin
        int lat, stallLow, doneSeen;
        logic expDz;
        logic [W-1:0] eh, el;

        rst = 1'b1; start = 1'b0; flush = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
        hiloRead = 1'b0; op = 2'd0; srcA = '0; srcB = '0; hiloWriteData = '0;
        step(); step();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_divZero", 64'(divZero), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        rst = 1'b0;
        step();

        tbl[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        tbl[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        tbl[3] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[5] = '{2'd3, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1};
        tbl[6] = '{2'd0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b1};
        tbl[7] = '{2'd3, 32'h0000_000A, 32'h0000_0003, 32'h0000_0001, 32'h0000_0003, 1'b0};
        tbl[8] = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        tbl[9] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};

        // Back-to-back: each op starts in the previous op's done cycle
        for (int i = 0; i < 10; i++) begin
            launch(tbl[i].op, tbl[i].a, tbl[i].b);
            waitDone(lat);
            checkLatency($sformatf("tbl%0d_lat", i), lat);
            check($sformatf("tbl%0d_hi", i), 64'(hi), 64'(tbl[i].expHi));
            check($sformatf("tbl%0d_lo", i), 64'(lo), 64'(tbl[i].expLo));
            check($sformatf("tbl%0d_dz", i), 64'(divZero), 64'(tbl[i].expDz));
        end
        expDz = 1'b1;

        for (int i = 0; i < 40; i++) begin
            logic [1:0] o;
            logic [W-1:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            refModel(o, a, b, eh, el);
            if (o[1]) expDz = (b == 0);
            launch(o, a, b);
            waitDone(lat);
            check($sformatf("rnd%0d_op%0d_%h_%h_hi", i, o, a, b), 64'(hi), 64'(eh));
            check($sformatf("rnd%0d_op%0d_%h_%h_lo", i, o, a, b), 64'(lo), 64'(el));
            check($sformatf("rnd%0d_dz", i), 64'(divZero), 64'(expDz));
        end
        step();

        // MTLO in IDLE
        loWrite = 1'b1; hiloWriteData = 32'h0000_1234;
        step();
        loWrite = 1'b0;
        check("mtlo_idle", 64'(lo), 64'h1234);

        // MTHI together with start: write lands, result later overwrites it
        hiWrite = 1'b1; hiloWriteData = 32'h0000_5555;
        launch(2'd1, 32'd2, 32'd3);
        hiWrite = 1'b0;
        check("mthi_with_start", 64'(hi), 64'h5555);
        waitDone(lat);
        check("mthi_start_hi", 64'(hi), 64'h0);
        check("mthi_start_lo", 64'(lo), 64'h6);

        // MTHI while busy is ignored and stalls
        launch(2'd1, 32'd6, 32'd7);
        hiWrite = 1'b1; hiloWriteData = 32'hDEAD_BEEF;
        #1;
        check("mthi_busy_stall", 64'(stall), 64'(1));
        step();
        hiWrite = 1'b0;
        check("mthi_busy_hi", 64'(hi), 64'h0);
        waitDone(lat);
        check("mthi_busy_lo", 64'(lo), 64'd42);

        // start while busy is neither accepted nor queued
        launch(2'd1, 32'd4, 32'd5);
        repeat (3) step();
        op = 2'd3; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        waitDone(lat);
        checkLatency("start_busy_lat", lat + 4);
        check("start_busy_lo", 64'(lo), 64'd20);
        step();
        check("start_busy_not_queued", 64'(busy), 64'(0));

        // flush in IDLE drops a coincident start
        flush = 1'b1;
        launch(2'd1, 32'd9, 32'd9);
        flush = 1'b0;
        check("flush_idle_start", 64'(busy), 64'(0));

        // Leave divZero set so flush and reset have something to preserve/clear
        launch(2'd3, 32'd1, 32'd0);
        waitDone(lat);
        check("dz_set", 64'(divZero), 64'(1));

        // Stall tracks hiloRead while busy and drops in the done cycle
        hiloRead = 1'b1;
        launch(2'd1, 32'd6, 32'd7);
        stallLow = 0;
        lat = 0;
        while (!done && lat < 200) begin
            if (!stall) stallLow++;
            step();
            lat++;
        end
        check("stall_busy_low_cycles", 64'(stallLow), 64'(0));
        check("stall_done_cycle", 64'(stall), 64'(0));
        check("stall_done_seen", 64'(done), 64'(1));
        checkLatency("stall_lat", lat);
        check("stall_hi", 64'(hi), 64'h0);
        check("stall_lo", 64'(lo), 64'd42);
        hiloRead = 1'b0;

        // Flush at cycle 5 of an op
        launch(2'd1, 32'd3, 32'd3);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_hi", 64'(hi), 64'h0);
        check("flush_lo", 64'(lo), 64'd42);
        check("flush_dz", 64'(divZero), 64'(1));
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) doneSeen++;
            step();
        end
        check("flush_no_done", 64'(doneSeen), 64'(0));

        // Reset at cycle 10 of an op
        launch(2'd1, 32'd9, 32'd9);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_divZero", 64'(divZero), 64'(0));
        check("midrst_hi", 64'(hi), 64'(0));
        check("midrst_lo", 64'(lo), 64'(0));
        check("midrst_stall", 64'(stall), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the EX stage of the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the results in HI/LO registers. It exposes a busy/stall handshake to the hazard unit and accepts EX-stage flushes. It also serves MTHI/MTLO writes and MFHI/MFLO reads.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (>=4, even).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  launch op; sampled only in IDLE
op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
srcA  input  WIDTH  multiplicand / dividend (forwarded EX operand A)
srcB  input  WIDTH  multiplier / divisor (forwarded EX operand B)
flush  input  1  abort in-flight op (EX flush)
hiWrite  input  1  MTHI
loWrite  input  1  MTLO
hiloWriteData  input  WIDTH  data for MTHI/MTLO
hiloRead  input  1  ID/EX instruction is MFHI/MFLO
busy  output  1  operation in flight
stall  output  1  to hazard unit: freeze PC, IF/ID, ID/EX
done  output  1  one-cycle pulse, result committed
divZero  output  1  sticky: last divide had srcB==0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; busy, done, divZero, hi, lo = 0; counter = 0. Reset wins over every other input, including mid-operation.
- FSM states: IDLE, RUN, FIXUP.
  - IDLE -> RUN on start.
  - RUN -> FIXUP after WIDTH iterations.
  - FIXUP -> IDLE unconditionally.
  - Any state -> IDLE on flush.
- Start at edge k:
  - Latch op and the sign flags of srcA/srcB.
  - Latch |srcA| and |srcB| for signed ops, raw values for unsigned ops.
  - Clear counter; busy=1 from the cycle after edge k.
- RUN, one iteration per edge:
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder is WIDTH+1 bits.
- FIXUP (edge k+WIDTH+1):
  - Apply sign correction.
  - Write hi/lo.
  - Pulse done; busy=0.
  - Fixed latency: done high WIDTH+1 cycles after the start edge.
- Signed product: negate the 2*WIDTH result if signA^signB.
- Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
- Results: lo=product[WIDTH-1:0], hi=product[2*WIDTH-1:WIDTH]; lo=quotient, hi=remainder.
- Divide by zero: lo = all ones, hi = srcA; divZero set. divZero is cleared by the next divide with nonzero divisor.
- Signed MIN / -1: lo=MIN, hi=0; no trap.
- start while busy: ignored; the op is not queued.
- start in the cycle done=1: accepted (state is IDLE).
- flush while busy: next cycle busy=0; hi, lo and divZero unchanged; no done pulse. flush in IDLE together with start: start is dropped.
- hiWrite/loWrite in IDLE: write takes effect next edge.
- hiWrite/loWrite while busy: ignored; the hazard unit holds them via stall.
- hiWrite/loWrite together with start in IDLE: the write happens, and the later result overwrites it.
- stall = busy & (hiloRead | start | hiWrite | loWrite). It is combinational and deasserts in the cycle done=1.

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined: a multiply leaves RUN for FIXUP as soon as the remaining unshifted multiplier bits are all zero. Accumulator alignment is completed by a single barrel shift in FIXUP. Divides with divisor > dividend (unsigned magnitudes) finish in FIXUP after 1 RUN cycle with lo=0, hi=dividend (sign-corrected). Latency varies (min 2 cycles); done/busy semantics are unchanged.
- Undefined: fixed WIDTH+1 latency for every op.

Decomposition:
- Package muldiv_pkg holds:
  - the op enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (S_IDLE, S_RUN, S_FIXUP);
  - DEFAULT_WIDTH = 32.
- One sub-module, muldiv_sign_fix: combinational abs-in/negate-out helper, parametrised by WIDTH. It is instantiated for operand magnitudes and result correction.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 10 / 0 -> lo=0xFFFFFFFF, hi=0x0000000A, divZero=1. Next DIVU 10/3 -> lo=3, hi=1, divZero=0.
- Start MULTU 6x7; hiloRead=1 throughout -> stall=1 until the done cycle; then hi=0, lo=42. flush at cycle 5 of a second op -> busy=0 next cycle, hi/lo stay 0/42. rst at cycle 10 of a third op -> all outputs 0.
- MTLO 0x1234 in IDLE -> lo=0x1234 next cycle. MTHI during busy -> hi unchanged, stall=1.
